// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings and the operand/destination match used for load-use detection
package decode_pkg;
  typedef enum logic [1:0] {IMM_I = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_J = 2'd3} immSel_e;
  localparam int BANK_INT = 0;
  localparam int BANK_FP  = 1;
  // A used source matches the ID/EX destination; the hardwired integer zero never matches.
  function automatic logic srcMatch(input logic used, input logic [31:0] srcBank, input logic [31:0] srcAddr,
                                    input logic [31:0] dstBank, input logic [31:0] dstAddr);
    return used && srcBank == dstBank && srcAddr == dstAddr && !(srcBank == BANK_INT && srcAddr == 0);
  endfunction
endpackage

// File: rtl/regbank.sv
// regbank: one register bank with a single write port and two write-through read ports
module regbank #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter bit HARD_ZERO = 1'b0,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] regs [NREG];
  logic blockZero;
  assign blockZero = HARD_ZERO && waddr == '0;
  // Storage: cleared on reset; writes to the hardwired zero are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (we && !blockZero) regs[waddr] <= wdata;
  end
  // Reads see a same-cycle write so the decoded operand is never stale.
  always_comb begin
    rdata1 = (HARD_ZERO && raddr1 == '0) ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
    rdata2 = (HARD_ZERO && raddr2 == '0) ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
  end
endmodule

// File: rtl/decode_stage_banked.sv
// decode_stage_banked: banked register read, immediate generation and the ID/EX register with load-use stall
module decode_stage_banked
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NBANK = 2,
  parameter int CTRL_W = 16,
  localparam int AW = $clog2(NREG),
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [1:0]        in_imm_sel,
  input  logic [1:0]        in_rs_used,
  input  logic [BW-1:0]     in_rs1_bank,
  input  logic [BW-1:0]     in_rs2_bank,
  input  logic [BW-1:0]     in_rd_bank,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [BW-1:0]     wb_bank,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [AW-1:0]     out_rd,
  output logic [BW-1:0]     out_rd_bank,
  output logic              out_rd_we,
  output logic              out_is_load
);
  logic [AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] rd1 [NBANK];
  logic [XLEN-1:0] rd2 [NBANK];
  logic [31:0] imm32;
  logic [XLEN-1:0] immX;
  logic hazard, accept, unusedBits;
  assign rs1 = in_instr[15 +: AW];
  assign rs2 = in_instr[20 +: AW];
  assign rd = in_instr[7 +: AW];
  assign unusedBits = ^{in_instr[6:0], in_instr[14:12]};
  genvar b;
  for (b = 0; b < NBANK; b++) begin : gBank
    regbank #(.XLEN(XLEN), .NREG(NREG), .HARD_ZERO(b == BANK_INT)) uBank (
      .clk(clk), .rst_n(rst_n),
      .we(wb_we && wb_bank == BW'(b)), .waddr(wb_addr), .wdata(wb_data),
      .raddr1(rs1), .raddr2(rs2), .rdata1(rd1[b]), .rdata2(rd2[b])
    );
  end
  // Immediate assembly from the instruction word, sign-extended from bit 31.
  always_comb begin
    imm32 = in_imm_sel == IMM_I ? {{20{in_instr[31]}}, in_instr[31:20]} :
            in_imm_sel == IMM_S ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
            in_imm_sel == IMM_B ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                                  {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    immX = XLEN'($signed(imm32));
  end
  // Load-use stall: a load in ID/EX whose result a source of the incoming instruction needs.
  always_comb begin
    hazard = out_valid && out_is_load && out_rd_we &&
             (srcMatch(in_rs_used[0], 32'(in_rs1_bank), 32'(rs1), 32'(out_rd_bank), 32'(out_rd)) ||
              srcMatch(in_rs_used[1], 32'(in_rs2_bank), 32'(rs2), 32'(out_rd_bank), 32'(out_rd)));
    in_ready = (!out_valid || out_ready) && !hazard;
    accept = in_valid && in_ready;
  end
  // ID/EX register: flush beats capture beats drain; data fields only move on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm <= '0;
      out_ctrl <= '0;
      out_rd <= '0;
      out_rd_bank <= '0;
      out_rd_we <= 1'b0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_rs1_data <= rd1[in_rs1_bank];
      out_rs2_data <= rd2[in_rs2_bank];
      out_imm <= immX;
      out_ctrl <= in_ctrl;
      out_rd <= rd;
      out_rd_bank <= in_rd_bank;
      out_rd_we <= in_rd_we;
      out_is_load <= in_is_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage_banked.sv
// tb_decode_stage_banked: scoreboard bench for the banked decode stage
module tb_decode_stage_banked;
  logic clk = 1'b0, rst_n;
  logic in_valid, in_ready, in_rd_we, in_is_load, flush, wb_we, out_valid, out_ready, out_rd_we, out_is_load;
  logic [31:0] in_instr, wb_data, out_rs1_data, out_rs2_data, out_imm;
  logic [15:0] in_ctrl, out_ctrl;
  logic [1:0] in_imm_sel, in_rs_used;
  logic in_rs1_bank, in_rs2_bank, in_rd_bank, wb_bank, out_rd_bank;
  logic [4:0] wb_addr, out_rd;

  typedef struct {
    logic [31:0] rs1, rs2, imm;
    logic [15:0] ctrl;
    logic [4:0] rd;
    logic rdBank, rdWe, isLoad;
  } exp_t;
  exp_t q[$];
  logic [31:0] mdl [2][32];
  int checks = 0, failures = 0;
  logic sInReady, sOutValid;

  always #5 clk = ~clk;

  decode_stage_banked dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_ctrl(in_ctrl),
    .in_imm_sel(in_imm_sel), .in_rs_used(in_rs_used), .in_rs1_bank(in_rs1_bank), .in_rs2_bank(in_rs2_bank),
    .in_rd_bank(in_rd_bank), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .flush(flush), .wb_we(wb_we),
    .wb_bank(wb_bank), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .out_rd(out_rd), .out_rd_bank(out_rd_bank), .out_rd_we(out_rd_we), .out_is_load(out_is_load)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic bank, input logic [4:0] a);
    if (!bank && a == 0) return 32'h0;
    if (wb_we && wb_bank == bank && wb_addr == a) return wb_data;
    return mdl[bank][a];
  endfunction

  function automatic logic [31:0] immOf(input logic [31:0] i, input logic [1:0] s);
    logic [31:0] r;
    case (s)
      2'd0: r = {{20{i[31]}}, i[31:20]};
      2'd1: r = {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2: r = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      default: r = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return {7'h00, r2, r1, 3'b000, rd, 7'h33};
  endfunction

  task automatic clearModel();
    for (int b = 0; b < 2; b++) for (int i = 0; i < 32; i++) mdl[b][i] = 32'h0;
    q.delete();
  endtask

  task automatic drive(input logic [31:0] instr, input logic [1:0] sel, input logic [1:0] used,
                       input logic b1, input logic b2, input logic bd, input logic we, input logic ld);
    in_valid = 1'b1; in_instr = instr; in_imm_sel = sel; in_rs_used = used;
    in_rs1_bank = b1; in_rs2_bank = b2; in_rd_bank = bd; in_rd_we = we; in_is_load = ld;
    in_ctrl = 16'($urandom);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic en, input logic bank, input logic [4:0] a, input logic [31:0] d);
    wb_we = en; wb_bank = bank; wb_addr = a; wb_data = d;
  endtask

  // One clock: observe outputs at the falling edge, update scoreboard and model, return just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    sInReady = in_ready;
    sOutValid = out_valid;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("extra_out", 64'(q.size()), 64'd1);
      else begin
        e = q.pop_front();
        check("rs1", out_rs1_data, e.rs1);
        check("rs2", out_rs2_data, e.rs2);
        check("imm", out_imm, e.imm);
        check("ctrl", out_ctrl, e.ctrl);
        check("rd", out_rd, e.rd);
        check("flags", {out_rd_bank, out_rd_we, out_is_load}, {e.rdBank, e.rdWe, e.isLoad});
      end
    end else if (out_valid && flush && q.size() != 0) begin
      void'(q.pop_front());
    end
    if (in_valid && in_ready && !flush) begin
      e.rs1 = mrd(in_rs1_bank, in_instr[19:15]);
      e.rs2 = mrd(in_rs2_bank, in_instr[24:20]);
      e.imm = immOf(in_instr, in_imm_sel);
      e.ctrl = in_ctrl;
      e.rd = in_instr[11:7];
      e.rdBank = in_rd_bank;
      e.rdWe = in_rd_we;
      e.isLoad = in_is_load;
      q.push_back(e);
    end
    if (wb_we && !(!wb_bank && wb_addr == 0)) mdl[wb_bank][wb_addr] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) cycle();
    check("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] immList [5];
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(); drive(32'h0, 2'd0, 2'b00, 0, 0, 0, 0, 0); idle();
    wb(0, 0, 0, 0);
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rs1", out_rs1_data, 0);
    check("rst_imm", out_imm, 0);
    check("rst_flags", {out_rd_we, out_is_load}, 2'b00);
    rst_n = 1'b1;
    cycle();

    // Plain register read after a write.
    wb(1, 0, 5, 32'hDEADBEEF); cycle();
    wb(0, 0, 0, 0); drive(mk(6, 5, 0), 2'd0, 2'b01, 0, 0, 0, 1, 0); cycle();
    idle(); cycle();
    check("x5_read_latency", sOutValid, 1);

    // Same-cycle write-through, and bank isolation.
    wb(1, 1, 3, 32'h3F800000); drive(mk(1, 3, 0), 2'd0, 2'b01, 1, 0, 1, 1, 0); cycle();
    wb(0, 0, 0, 0); drive(mk(1, 3, 0), 2'd0, 2'b01, 0, 0, 0, 1, 0); cycle();
    idle(); cycle();

    // Hardwired zero only in bank 0.
    wb(1, 0, 0, 32'h1234); cycle();
    wb(0, 0, 0, 0); drive(mk(2, 0, 0), 2'd0, 2'b11, 0, 0, 0, 1, 0); cycle();
    idle(); wb(1, 1, 0, 32'h1234); cycle();
    wb(0, 0, 0, 0); drive(mk(2, 0, 0), 2'd0, 2'b11, 1, 1, 1, 1, 0); cycle();
    idle(); cycle();
    drain();

    // Load-use on the integer bank: one stall cycle, one bubble.
    drive(mk(7, 1, 0), 2'd0, 2'b01, 0, 0, 0, 1, 1); cycle();
    drive(mk(8, 0, 7), 2'd1, 2'b10, 0, 0, 0, 1, 0); cycle();
    check("ld_stall_ready", sInReady, 0);
    cycle();
    check("ld_bubble_valid", sOutValid, 0);
    check("ld_after_ready", sInReady, 1);
    idle(); cycle();
    check("ld_dep_issued", sOutValid, 1);
    drain();

    // Load into the float bank, consumer reads the integer bank: no stall.
    drive(mk(7, 1, 0), 2'd0, 2'b01, 0, 0, 1, 1, 1); cycle();
    drive(mk(8, 0, 7), 2'd1, 2'b10, 0, 0, 0, 1, 0); cycle();
    check("ld_xbank_ready", sInReady, 1);
    idle(); cycle();
    drain();

    // Back-pressure from EX holds the stage.
    wb(1, 0, 12, 32'hCAFEF00D); drive(mk(9, 12, 5), 2'd2, 2'b11, 0, 0, 0, 1, 0); cycle();
    wb(0, 0, 0, 0); out_ready = 1'b0; drive(mk(10, 5, 12), 2'd3, 2'b11, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_ready", sInReady, 0);
      check("stall_valid", out_valid, 1);
      check("stall_rs1", out_rs1_data, q[0].rs1);
      check("stall_imm", out_imm, q[0].imm);
    end
    out_ready = 1'b1; cycle();
    idle(); cycle();
    drain();

    // Immediate formats.
    drive(32'hFFF00093, 2'd0, 2'b01, 0, 0, 0, 1, 0); cycle();
    idle();
    check("imm_i_neg1", out_imm, 32'hFFFFFFFF);
    immList = '{32'h12345678, 32'h80000FE3, 32'h7FFFF0EF, 32'hA5A5A5A5, $urandom};
    for (int j = 0; j < 5; j++)
      for (int s = 0; s < 4; s++) begin
        drive(immList[j], 2'(s), 2'b11, 1'(s), 1'(j), 0, 1, 0);
        cycle();
      end
    drain();

    // Flush beats capture, and kills a held instruction.
    flush = 1'b1; drive(mk(3, 5, 5), 2'd0, 2'b11, 0, 0, 0, 1, 0); cycle();
    check("flush_capture_valid", out_valid, 0);
    flush = 1'b0; cycle();
    idle(); out_ready = 1'b0; flush = 1'b1; cycle();
    check("flush_held_valid", out_valid, 0);
    flush = 1'b0; out_ready = 1'b1;
    check("flush_q_empty", 64'(q.size()), 64'd0);

    // Asynchronous reset mid-stream clears pipeline and every bank.
    wb(1, 0, 9, 32'h0000AAAA); cycle();
    wb(1, 1, 9, 32'h0000BBBB); drive(mk(4, 9, 12), 2'd0, 2'b11, 0, 0, 0, 1, 0); cycle();
    wb(0, 0, 0, 0); drive(mk(4, 9, 9), 2'd0, 2'b11, 1, 1, 1, 1, 0); cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    clearModel();
    rst_n = 1'b1;
    cycle();
    drive(mk(4, 9, 12), 2'd0, 2'b11, 0, 0, 0, 1, 0); cycle();
    check("arst_x9", out_rs1_data, 0);
    drive(mk(4, 9, 9), 2'd0, 2'b11, 1, 1, 1, 1, 0); cycle();
    check("arst_f9", out_rs2_data, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
